// File: rtl/l2_write_buffer.sv
// L2-side write-back buffer: accepts DL1 dirty lines, coalesces repeat words,
// drains them to memory in FIFO order and forwards buffered data to L2 misses.
module l2_write_buffer #(
  parameter int DATA_LENGTH = 32,
  parameter int BYTE_OFFSET = 2,
  parameter int WB_DEPTH    = 4
) (
  input  logic                                   clk_l2,
  input  logic                                   rst,
  input  logic                                   wb_req,
  input  logic [2*DATA_LENGTH-BYTE_OFFSET-1:0]   wb_data,
  output logic                                   wb_ack,
  output logic                                   full_flag,
  output logic                                   empty_flag,
  input  logic                                   drain_hold,
  output logic                                   data_write_req,
  output logic [DATA_LENGTH-1:0]                 data_addr,
  output logic [DATA_LENGTH-1:0]                 data_mem_write,
  input  logic                                   data_res,
  input  logic [DATA_LENGTH-1:0]                 chk_addr,
  output logic                                   chk_hit,
  output logic [DATA_LENGTH-1:0]                 chk_data
);
  localparam int AW = DATA_LENGTH - BYTE_OFFSET;
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WB_DEPTH-1:0]    valid_q, valid_d;
  logic                   wb_ack_q, wb_ack_d;
  logic [AW-1:0]          addr_q [WB_DEPTH];
  logic [AW-1:0]          addr_d [WB_DEPTH];
  logic [DATA_LENGTH-1:0] data_q [WB_DEPTH];
  logic [DATA_LENGTH-1:0] data_d [WB_DEPTH];

  logic [AW-1:0]          in_addr;
  logic [DATA_LENGTH-1:0] in_data;
  logic                   coal_hit;
  logic [PW-1:0]          coal_idx;
  logic [PW-1:0]          idx;
  logic                   accept, push, pop;

  assign in_addr        = wb_data[2*DATA_LENGTH-BYTE_OFFSET-1:DATA_LENGTH];
  assign in_data        = wb_data[DATA_LENGTH-1:0];
  assign wb_ack         = wb_ack_q;
  assign full_flag      = (count_q == CW'(WB_DEPTH));
  assign empty_flag     = (count_q == '0);
  assign data_write_req = (state_q == S_WRITE);
  assign data_addr      = {addr_q[rd_ptr_q], {BYTE_OFFSET{1'b0}}};
  assign data_mem_write = data_q[rd_ptr_q];

  // Walk entries oldest-to-newest so the last match seen is the newest one.
  always_comb begin
    chk_hit  = 1'b0;
    chk_data = '0;
    coal_hit = 1'b0;
    coal_idx = '0;
    idx      = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (valid_q[idx] && addr_q[idx] == chk_addr[DATA_LENGTH-1:BYTE_OFFSET]) begin
        chk_hit  = 1'b1;
        chk_data = data_q[idx];
      end
      // The head being written to memory must not change underneath the write.
      if (valid_q[idx] && addr_q[idx] == in_addr &&
          !(idx == rd_ptr_q && state_q != S_IDLE)) begin
        coal_hit = 1'b1;
        coal_idx = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pop      = 1'b0;
    push     = 1'b0;

    accept   = wb_req && !wb_ack_q && (coal_hit || count_q < CW'(WB_DEPTH));
    wb_ack_d = accept;

    case (state_q)
      S_IDLE:  if (count_q != '0 && !drain_hold) state_d = S_WRITE;
      S_WRITE: if (data_res) begin
                 pop     = 1'b1;
                 state_d = S_DONE;
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end

    if (accept) begin
      if (coal_hit) begin
        data_d[coal_idx] = in_data;
      end else begin
        push              = 1'b1;
        addr_d[wr_ptr_q]  = in_addr;
        data_d[wr_ptr_q]  = in_data;
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + 1'b1;
      end
    end

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_l2 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      wb_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      wb_ack_q <= wb_ack_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_l2) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed self-checking bench for l2_write_buffer: reset, single write, full,
// coalesce, forwarding and reset during a memory write.
module tb_l2_write_buffer;
  localparam int DL = 32;
  localparam int BO = 2;

  logic              clk_l2 = 1'b0;
  logic              rst;
  logic              wb_req;
  logic [2*DL-BO-1:0] wb_data;
  logic              wb_ack, full_flag, empty_flag;
  logic              drain_hold;
  logic              data_write_req;
  logic [DL-1:0]     data_addr, data_mem_write;
  logic              data_res;
  logic [DL-1:0]     chk_addr;
  logic              chk_hit;
  logic [DL-1:0]     chk_data;

  int n_checks = 0;
  int n_pass   = 0;

  l2_write_buffer #(.DATA_LENGTH(DL), .BYTE_OFFSET(BO), .WB_DEPTH(4)) dut (
    .clk_l2(clk_l2), .rst(rst), .wb_req(wb_req), .wb_data(wb_data),
    .wb_ack(wb_ack), .full_flag(full_flag), .empty_flag(empty_flag),
    .drain_hold(drain_hold), .data_write_req(data_write_req),
    .data_addr(data_addr), .data_mem_write(data_mem_write), .data_res(data_res),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .chk_data(chk_data)
  );

  always #5 clk_l2 = ~clk_l2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-16s got 0x%0h", tag, obs);
    end else begin
      $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_l2);
      if (wb_ack) got = 1'b1;
    end
    wb_req = 1'b0;
    check("wb_ack", {63'd0, got}, 64'd1);
  endtask

  task automatic do_write(input logic [31:0] ba, input logic [31:0] d);
    wb_data = {ba[31:2], d};
    wb_req  = 1'b1;
    wait_ack();
  endtask

  // Waits for a memory write, checks its payload, completes it and checks the bubble.
  task automatic drain_one(input logic [31:0] ea, input logic [31:0] ed);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_l2);
      if (data_write_req) got = 1'b1;
    end
    check("drain_req", {63'd0, got}, 64'd1);
    check("drain_addr", {32'd0, data_addr}, {32'd0, ea});
    check("drain_data", {32'd0, data_mem_write}, {32'd0, ed});
    data_res = 1'b1;
    @(negedge clk_l2);
    data_res = 1'b0;
    check("bubble_req", {63'd0, data_write_req}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; wb_req = 1'b0; wb_data = '0; drain_hold = 1'b0;
    data_res = 1'b0; chk_addr = '0;

    // 1 reset state
    repeat (2) @(negedge clk_l2);
    check("rst_ack", {63'd0, wb_ack}, 64'd0);
    check("rst_req", {63'd0, data_write_req}, 64'd0);
    check("rst_full", {63'd0, full_flag}, 64'd0);
    check("rst_empty", {63'd0, empty_flag}, 64'd1);
    check("rst_hit", {63'd0, chk_hit}, 64'd0);
    rst = 1'b0;
    @(negedge clk_l2);

    // 2 single write with minimum drain latency and a 3-cycle memory response
    do_write(32'h10, 32'h567);
    check("lat_req_lo", {63'd0, data_write_req}, 64'd0);
    @(negedge clk_l2);
    check("lat_req_hi", {63'd0, data_write_req}, 64'd1);
    check("t2_addr", {32'd0, data_addr}, 64'h10);
    check("t2_data", {32'd0, data_mem_write}, 64'h567);
    repeat (2) begin
      @(negedge clk_l2);
      check("t2_req_hold", {63'd0, data_write_req}, 64'd1);
    end
    data_res = 1'b1;
    @(negedge clk_l2);
    data_res = 1'b0;
    check("t2_bubble", {63'd0, data_write_req}, 64'd0);
    check("t2_empty", {63'd0, empty_flag}, 64'd1);
    @(negedge clk_l2);
    check("t2_idle_req", {63'd0, data_write_req}, 64'd0);

    // 3 full buffer, blocked fifth write, FIFO drain order
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) do_write(32'(i * 4), 32'hA0 + 32'(i));
    check("t3_full", {63'd0, full_flag}, 64'd1);
    wb_data = {30'h40, 32'hA4};
    wb_req  = 1'b1;
    repeat (3) begin
      @(negedge clk_l2);
      check("t3_no_ack", {63'd0, wb_ack}, 64'd0);
    end
    drain_hold = 1'b0;
    drain_one(32'h0, 32'hA0);
    check("t3_pop_no_ack", {63'd0, wb_ack}, 64'd0);
    wait_ack();
    drain_one(32'h4, 32'hA1);
    drain_one(32'h8, 32'hA2);
    drain_one(32'hC, 32'hA3);
    drain_one(32'h100, 32'hA4);
    @(negedge clk_l2);
    check("t3_empty", {63'd0, empty_flag}, 64'd1);

    // 4 coalesce
    drain_hold = 1'b1;
    do_write(32'h40, 32'h1);
    do_write(32'h40, 32'h2);
    check("t4_not_empty", {63'd0, empty_flag}, 64'd0);
    drain_hold = 1'b0;
    drain_one(32'h40, 32'h2);
    check("t4_empty", {63'd0, empty_flag}, 64'd1);
    repeat (2) begin
      @(negedge clk_l2);
      check("t4_no_2nd", {63'd0, data_write_req}, 64'd0);
    end

    // 5 forwarding, including the head under drain and newest-match priority
    drain_hold = 1'b1;
    do_write(32'h80, 32'hABCD);
    chk_addr = 32'h80; #1;
    check("t5_hit80", {63'd0, chk_hit}, 64'd1);
    check("t5_data80", {32'd0, chk_data}, 64'hABCD);
    chk_addr = 32'h82; #1;
    check("t5_hit82", {63'd0, chk_hit}, 64'd1);
    check("t5_data82", {32'd0, chk_data}, 64'hABCD);
    chk_addr = 32'h84; #1;
    check("t5_miss84", {63'd0, chk_hit}, 64'd0);
    check("t5_data84", {32'd0, chk_data}, 64'd0);
    drain_hold = 1'b0;
    @(negedge clk_l2);
    check("t5_in_write", {63'd0, data_write_req}, 64'd1);
    chk_addr = 32'h80; #1;
    check("t5_hit_head", {63'd0, chk_hit}, 64'd1);
    do_write(32'h80, 32'h1234);
    chk_addr = 32'h80; #1;
    check("t5_newest", {32'd0, chk_data}, 64'h1234);
    drain_one(32'h80, 32'hABCD);
    drain_one(32'h80, 32'h1234);

    // 6 reset during a memory write
    do_write(32'h200, 32'h55);
    @(negedge clk_l2);
    check("t6_in_write", {63'd0, data_write_req}, 64'd1);
    chk_addr = 32'h200;
    #2 rst = 1'b1;
    #1;
    check("t6_req_drop", {63'd0, data_write_req}, 64'd0);
    check("t6_empty", {63'd0, empty_flag}, 64'd1);
    check("t6_hit", {63'd0, chk_hit}, 64'd0);
    @(negedge clk_l2);
    rst = 1'b0;
    data_res = 1'b1;
    @(negedge clk_l2);
    data_res = 1'b0;
    check("t6_res_ign", {63'd0, data_write_req}, 64'd0);
    check("t6_empty2", {63'd0, empty_flag}, 64'd1);
    @(negedge clk_l2);
    check("t6_idle", {63'd0, data_write_req}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
